// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store memory responder.
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_HI,
    WR_ACK,
    RD_LO,
    RD_HI,
    RD_ACK
  } state_e;

  localparam logic [2:0] W_BYTE = 3'd1;
  localparam logic [2:0] W_HALF = 3'd2;
  localparam logic [2:0] W_WORD = 3'd4;

  // Byte-lane mask for a store width; zero marks an illegal width.
  function automatic logic [3:0] width_to_mask(input logic [2:0] width);
    logic [3:0] mask;
    case (width)
      W_BYTE:  mask = 4'b0001;
      W_HALF:  mask = 4'b0011;
      W_WORD:  mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mem_responder_byte_lane_align.sv
// Store-side lane steering: spreads a 1/2/4-byte store across two RAM words.
module byte_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_width,
  input  logic [31:0] i_data,
  output logic [3:0]  o_be_lo,
  output logic [3:0]  o_be_hi,
  output logic [31:0] o_wdata_lo,
  output logic [31:0] o_wdata_hi,
  output logic        o_split
);

  logic [7:0]  w_be_wide;
  logic [63:0] w_data_wide;

  // Shift mask and data by the byte offset over a two-word window.
  always_comb begin
    w_be_wide   = {4'b0000, width_to_mask(i_width)} << i_off;
    w_data_wide = {32'h0, i_data} << {i_off, 3'b000};
    o_be_lo     = w_be_wide[3:0];
    o_be_hi     = w_be_wide[7:4];
    o_wdata_lo  = w_data_wide[31:0];
    o_wdata_hi  = w_data_wide[63:32];
    o_split     = |w_be_wide[7:4];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: turns core load/store requests into single-port RAM beats.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned RAM_AW = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_data,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [2:0]        i_wr_width,
  output logic [31:0]       o_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic              o_bad_width,
  output logic              o_ram_en,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [3:0]        o_ram_be,
  output logic [31:0]       o_ram_wdata,
  input  logic [31:0]       i_ram_rdata
);

  state_e            r_state;
  logic [RAM_AW-1:0] r_word;
  logic [1:0]        r_off;
  logic [3:0]        r_be_hi;
  logic [31:0]       r_wdata_hi;
  logic [31:0]       r_lo;
  logic              r_wr_ready;
  logic              r_rd_valid;
  logic              r_bad_width;
  logic [31:0]       r_data;

  logic [RAM_AW-1:0] w_word;
  logic [RAM_AW-1:0] w_word_next;
  logic [1:0]        w_off;
  logic              w_legal;
  logic [3:0]        w_be_lo;
  logic [3:0]        w_be_hi;
  logic [31:0]       w_wdata_lo;
  logic [31:0]       w_wdata_hi;
  logic              w_split;
  logic [63:0]       w_rd_cat;
  logic [31:0]       w_rd_aligned;
  logic              w_unused_addr;

  assign w_word        = i_addr[RAM_AW+1:2];
  assign w_off         = i_addr[1:0];
  assign w_word_next   = r_word + RAM_AW'(1);
  assign w_legal       = (width_to_mask(i_wr_width) != 4'b0000);
  assign w_unused_addr = ^i_addr[31:RAM_AW+2];

  byte_lane_align u_align (
    .i_off      (w_off),
    .i_width    (i_wr_width),
    .i_data     (i_data),
    .o_be_lo    (w_be_lo),
    .o_be_hi    (w_be_hi),
    .o_wdata_lo (w_wdata_lo),
    .o_wdata_hi (w_wdata_hi),
    .o_split    (w_split)
  );

  // Load realignment: high word above low word, shifted down by the byte offset.
  always_comb begin
    w_rd_cat     = {i_ram_rdata, r_lo};
    w_rd_aligned = 32'(w_rd_cat >> {r_off, 3'b000});
  end

  // RAM strobes are driven from the current state so read data lines up with RD_LO/RD_HI.
  always_comb begin
    o_ram_en    = 1'b0;
    o_ram_addr  = '0;
    o_ram_be    = '0;
    o_ram_wdata = '0;
    if (!i_rst) begin
      case (r_state)
        IDLE: begin
          if (i_wr_valid) begin
            if (w_legal) begin
              o_ram_en    = 1'b1;
              o_ram_addr  = w_word;
              o_ram_be    = w_be_lo;
              o_ram_wdata = w_wdata_lo;
            end
          end else if (i_rd_ready) begin
            o_ram_en   = 1'b1;
            o_ram_addr = w_word;
          end
        end
        WR_HI: begin
          o_ram_en    = 1'b1;
          o_ram_addr  = w_word_next;
          o_ram_be    = r_be_hi;
          o_ram_wdata = r_wdata_hi;
        end
        RD_LO: begin
          if (i_rd_ready && (r_off != 2'd0)) begin
            o_ram_en   = 1'b1;
            o_ram_addr = w_word_next;
          end
        end
        default: ;
      endcase
    end
  end

  // Request sequencing with registered handshake and load-data outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_word      <= '0;
      r_off       <= '0;
      r_be_hi     <= '0;
      r_wdata_hi  <= '0;
      r_lo        <= '0;
      r_wr_ready  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_bad_width <= 1'b0;
      r_data      <= '0;
    end else begin
      r_wr_ready  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_bad_width <= 1'b0;
      r_data      <= '0;
      case (r_state)
        IDLE: begin
          if (i_wr_valid) begin
            r_word     <= w_word;
            r_be_hi    <= w_be_hi;
            r_wdata_hi <= w_wdata_hi;
            if (!w_legal) begin
              r_bad_width <= 1'b1;
              r_wr_ready  <= 1'b1;
              r_state     <= WR_ACK;
            end else if (w_split) begin
              r_state <= WR_HI;
            end else begin
              r_wr_ready <= 1'b1;
              r_state    <= WR_ACK;
            end
          end else if (i_rd_ready) begin
            r_word  <= w_word;
            r_off   <= w_off;
            r_state <= RD_LO;
          end
        end
        // Second beat is always written; only the ack depends on the request still being up.
        WR_HI: begin
          if (i_wr_valid) begin
            r_wr_ready <= 1'b1;
            r_state    <= WR_ACK;
          end else begin
            r_state <= IDLE;
          end
        end
        WR_ACK: r_state <= IDLE;
        RD_LO: begin
          if (!i_rd_ready) begin
            r_state <= IDLE;
          end else begin
            r_lo <= i_ram_rdata;
            if (r_off == 2'd0) begin
              r_data     <= i_ram_rdata;
              r_rd_valid <= 1'b1;
              r_state    <= RD_ACK;
            end else begin
              r_state <= RD_HI;
            end
          end
        end
        RD_HI: begin
          if (!i_rd_ready) begin
            r_state <= IDLE;
          end else begin
            r_data     <= w_rd_aligned;
            r_rd_valid <= 1'b1;
            r_state    <= RD_ACK;
          end
        end
        RD_ACK: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_wr_ready  = r_wr_ready;
  assign o_rd_valid  = r_rd_valid;
  assign o_bad_width = r_bad_width;
  assign o_data      = r_data;

endmodule
